gol_engine: RTL

- Parametrised Game of Life core: WIDTH x HEIGHT board, B3/S23 rule, selectable toroidal or dead-edge boundary.
- Double-buffered storage. The display reads a stable front buffer while the back buffer is computed one row per cycle.
- Generations are triggered by an internal tick divider or a manual step pulse.
- Keeps left/right edge scores and a generation count. Sits between the seed/control logic and the pixel renderer.

---
 rtl/gol_engine.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/gol_engine.sv
// Game of Life core: B3/S23 over a WIDTH x HEIGHT board, double-buffered,
// one back-buffer row per cycle, with edge scoring and a generation counter.

module gol_cell (
  input  logic       self_i,
  input  logic [7:0] nb_i,
  output logic       next_o
);
  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nb_i[i]};
  end

  assign next_o = (cnt == 4'd3) || (self_i && (cnt == 4'd2));
endmodule

module gol_engine #(
  parameter int WIDTH    = 10,
  parameter int HEIGHT   = 9,
  parameter int WRAP     = 0,
  parameter int TICK_DIV = 33554432,
  parameter int SCORE_W  = 10,
  parameter int GEN_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [5:0]         wr_x,
  input  logic [5:0]         wr_y,
  input  logic               wr_val,
  input  logic [5:0]         q_x,
  input  logic [5:0]         q_y,
  output logic               q_alive,
  output logic               busy,
  output logic               overrun,
  output logic [GEN_W-1:0]   gen_count,
  output logic [SCORE_W-1:0] l_score,
  output logic [SCORE_W-1:0] r_score
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_SWAP = 2'd2;

  typedef logic [HEIGHT-1:0][WIDTH-1:0] board_t;

  function automatic board_t glider_init();
    board_t b;
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        b[r][c] = (r == 6 && c == 6) || (r == 7 && c == 7) || (r == 8 && c >= 5 && c <= 7);
    return b;
  endfunction

  localparam board_t GLIDER = glider_init();

  function automatic logic [SCORE_W-1:0] sat_add(logic [SCORE_W-1:0] a, logic [6:0] p);
    logic [SCORE_W+7:0] s;
    s = {8'b0, a} + {{(SCORE_W+1){1'b0}}, p};
    return (s > {8'b0, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  board_t             buf0_q, buf0_d, buf1_q, buf1_d, front, back;
  logic               sel_q, sel_d, ovr_q, ovr_d;
  logic [1:0]         state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [SCORE_W-1:0] l_q, l_d, r_q, r_d;
  logic [WIDTH-1:0]   up, mid, dn, nrow;
  logic [6:0]         pop_l, pop_r;
  logic               tick_hit, trig, wr_hit;

  // sel_q=0: buf0 is displayed, buf1 is being computed.
  assign front = sel_q ? buf1_q : buf0_q;
  assign back  = sel_q ? buf0_q : buf1_q;

  assign tick_hit = run && (tick_q == TW'(TICK_DIV - 1));
  assign trig     = tick_hit || step;
  assign wr_hit   = wr_en && (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);

  assign up  = (row_q == '0) ? ((WRAP != 0) ? front[HEIGHT-1] : '0) : front[row_q - RW'(1)];
  assign mid = front[row_q];
  assign dn  = (row_q == RW'(HEIGHT - 1)) ? ((WRAP != 0) ? front[0] : '0) : front[row_q + RW'(1)];

  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    localparam int CL = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int CR = (c == WIDTH - 1) ? 0 : c + 1;
    localparam bit HL = (WRAP != 0) || (c > 0);
    localparam bit HR = (WRAP != 0) || (c < WIDTH - 1);
    logic [7:0] nb;
    assign nb = {HL ? up[CL]  : 1'b0, up[c], HR ? up[CR]  : 1'b0,
                 HL ? mid[CL] : 1'b0,        HR ? mid[CR] : 1'b0,
                 HL ? dn[CL]  : 1'b0, dn[c], HR ? dn[CR]  : 1'b0};
    gol_cell u_cell (.self_i(mid[c]), .nb_i(nb), .next_o(nrow[c]));
  end

  always_comb begin
    pop_l = '0;
    pop_r = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      pop_r = pop_r + {6'b0, back[r][0]};
      pop_l = pop_l + {6'b0, back[r][WIDTH-1]};
    end
  end

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    sel_d   = sel_q;
    ovr_d   = ovr_q;
    state_d = state_q;
    row_d   = row_q;
    gen_d   = gen_q;
    l_d     = l_q;
    r_d     = r_q;
    tick_d  = run ? (tick_hit ? '0 : tick_q + TW'(1)) : '0;
    if (clear) begin
      buf0_d  = '0;
      buf1_d  = '0;
      state_d = S_IDLE;
      row_d   = '0;
      gen_d   = '0;
      l_d     = '0;
      r_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_hit) begin
            if (sel_q) buf1_d[wr_y[RW-1:0]][wr_x[CW-1:0]] = wr_val;
            else       buf0_d[wr_y[RW-1:0]][wr_x[CW-1:0]] = wr_val;
          end
          if (trig) begin
            state_d = S_COMP;
            row_d   = '0;
          end
        end
        S_COMP: begin
          if (sel_q) buf0_d[row_q] = nrow;
          else       buf1_d[row_q] = nrow;
          if (trig) ovr_d = 1'b1;
          row_d = row_q + RW'(1);
          if (row_q == RW'(HEIGHT - 1)) state_d = S_SWAP;
        end
        S_SWAP: begin
          if (trig) ovr_d = 1'b1;
          sel_d   = ~sel_q;
          gen_d   = gen_q + GEN_W'(1);
          r_d     = sat_add(r_q, pop_r);
          l_d     = sat_add(l_q, pop_l);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q  <= GLIDER;
      buf1_q  <= '0;
      sel_q   <= 1'b0;
      ovr_q   <= 1'b0;
      state_q <= S_IDLE;
      row_q   <= '0;
      tick_q  <= '0;
      gen_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
    end else begin
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      sel_q   <= sel_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      row_q   <= row_d;
      tick_q  <= tick_d;
      gen_q   <= gen_d;
      l_q     <= l_d;
      r_q     <= r_d;
    end
  end

  assign q_alive   = (int'(q_x) < WIDTH) && (int'(q_y) < HEIGHT) && front[q_y[RW-1:0]][q_x[CW-1:0]];
  assign busy      = (state_q != S_IDLE);
  assign overrun   = ovr_q;
  assign gen_count = gen_q;
  assign l_score   = l_q;
  assign r_score   = r_q;
endmodule
